// File: rtl/pcm_dnlink_sim_pkg.sv
// Shared types and constants for the PCM downlink simulator: slot classes,
// default geometry and a width helper for counters and FIFO pointers.
package pcm_sim_pkg;

  typedef enum logic [1:0] {
    SLOT_STRT = 2'd0,
    SLOT_BSNC = 2'd1,
    SLOT_END  = 2'd2,
    SLOT_IDLE = 2'd3
  } slot_class_t;

  localparam int DEF_BIT_DIV         = 20;
  localparam int DEF_PULSE_LEN       = 4;
  localparam int DEF_WORD_BITS       = 40;
  localparam int DEF_WORDS_PER_FRAME = 1;
  localparam int DEF_FRAME_SLOTS     = 1024;
  localparam int DEF_FIFO_DEPTH      = 4;

  // Bits needed to hold 0..value-1; never less than 1 so degenerate sizes still elaborate.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pcm_dnlink_sim_fifo.sv
// Single-clock word FIFO with registered empty/full flags. A push while full
// is discarded and reported by a one-cycle dropped pulse; a same-cycle pop makes room.
module sync_fifo
  import pcm_sim_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             empty_reg;
  logic             full_reg;
  logic             dropped_reg;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop     = pop && !empty_reg;
    do_push    = push && (!full_reg || do_pop);
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg   <= count_next;
      empty_reg   <= (count_next == '0);
      full_reg    <= (count_next == (AW+1)'(DEPTH));
      dropped_reg <= push && !do_push;
    end
  end

  // Head entry is only rewritten after it has been popped, so it holds steady under backpressure.
  assign head_data = mem[rd_ptr_reg];
  assign empty     = empty_reg;
  assign dropped   = dropped_reg;

endmodule

// File: rtl/pcm_dnlink_sim.sv
// PCM downlink simulator: divides the AGC CLK into bit slots, drives the
// DKSTRT/DKBSNC/DKEND strobes and captures DKDATA words into a FIFO.
module pcm_dnlink_sim
  import pcm_sim_pkg::*;
#(
  parameter int BIT_DIV         = DEF_BIT_DIV,
  parameter int PULSE_LEN       = DEF_PULSE_LEN,
  parameter int WORD_BITS       = DEF_WORD_BITS,
  parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
  parameter int FRAME_SLOTS     = DEF_FRAME_SLOTS,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 agc_clk_in,
  input  logic                 dkdata_in,
  output logic                 dkstrt,
  output logic                 dkbsnc,
  output logic                 dkend,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overflow,
  output logic [15:0]          frame_count
);

  localparam int N  = WORD_BITS * WORDS_PER_FRAME;
  localparam int PW = clog2(BIT_DIV);
  localparam int SW = clog2(FRAME_SLOTS);
  localparam int BW = clog2(WORD_BITS);

  localparam logic [PW-1:0] PULSE_LAST  = PW'(BIT_DIV - 1);
  localparam logic [PW-1:0] PULSE_LEN_C = PW'(PULSE_LEN);
  localparam logic [PW-1:0] PULSE_CAP   = PW'(PULSE_LEN - 1);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(FRAME_SLOTS - 1);
  localparam logic [SW-1:0] BSNC_LAST   = SW'(N);
  localparam logic [SW-1:0] END_SLOT    = SW'(N + 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WORD_BITS - 1);

  logic agc_s1_reg, agc_s2_reg, agc_s3_reg, tick_reg;
  logic dk_s1_reg, dk_s2_reg;

  logic [PW-1:0] pulse_reg, pulse_next;
  logic [SW-1:0] slot_reg, slot_next;
  logic          frame_start;
  logic [15:0]   frame_count_reg;
  logic          dkstrt_reg, dkbsnc_reg, dkend_reg;
  slot_class_t   cur_class, next_class;
  logic          strobe_on;
  logic          capture;

  logic [WORD_BITS-1:0] shreg_reg, shift_word, push_data_reg;
  logic [BW-1:0]        bitcnt_reg;
  logic                 push_reg;

  logic fifo_empty, fifo_dropped, overflow_reg;

  function automatic slot_class_t classify(input logic [SW-1:0] s);
    if (s == '0) begin
      return SLOT_STRT;
    end else if (s <= BSNC_LAST) begin
      return SLOT_BSNC;
    end else if (s == END_SLOT) begin
      return SLOT_END;
    end
    return SLOT_IDLE;
  endfunction

  // Both asynchronous inputs share the same two-flop depth so data lines up with the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      agc_s1_reg <= 1'b0;
      agc_s2_reg <= 1'b0;
      agc_s3_reg <= 1'b0;
      tick_reg   <= 1'b0;
      dk_s1_reg  <= 1'b0;
      dk_s2_reg  <= 1'b0;
    end else begin
      agc_s1_reg <= agc_clk_in;
      agc_s2_reg <= agc_s1_reg;
      agc_s3_reg <= agc_s2_reg;
      tick_reg   <= agc_s2_reg && !agc_s3_reg;
      dk_s1_reg  <= dkdata_in;
      dk_s2_reg  <= dk_s1_reg;
    end
  end

  // Frame-end wrap is gated by enable; otherwise counters park on the last pulse of the last slot.
  always_comb begin
    pulse_next  = pulse_reg;
    slot_next   = slot_reg;
    frame_start = 1'b0;
    if (tick_reg) begin
      if (pulse_reg != PULSE_LAST) begin
        pulse_next = pulse_reg + PW'(1);
      end else if (slot_reg != SLOT_LAST) begin
        slot_next  = slot_reg + SW'(1);
        pulse_next = '0;
      end else if (enable) begin
        slot_next   = '0;
        pulse_next  = '0;
        frame_start = 1'b1;
      end
    end
  end

  always_comb begin
    cur_class  = classify(slot_reg);
    next_class = classify(slot_next);
    strobe_on  = (pulse_next < PULSE_LEN_C);
    capture    = tick_reg && (pulse_reg == PULSE_CAP) && (cur_class == SLOT_BSNC);
    shift_word = {shreg_reg[WORD_BITS-2:0], dk_s2_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_reg       <= PULSE_LAST;
      slot_reg        <= SLOT_LAST;
      frame_count_reg <= '0;
      dkstrt_reg      <= 1'b0;
      dkbsnc_reg      <= 1'b0;
      dkend_reg       <= 1'b0;
    end else begin
      pulse_reg  <= pulse_next;
      slot_reg   <= slot_next;
      if (frame_start) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
      dkstrt_reg <= strobe_on && (next_class == SLOT_STRT);
      dkbsnc_reg <= strobe_on && (next_class == SLOT_BSNC);
      dkend_reg  <= strobe_on && (next_class == SLOT_END);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg     <= '0;
      bitcnt_reg    <= '0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      if (frame_start) begin
        shreg_reg  <= '0;
        bitcnt_reg <= '0;
      end else if (capture) begin
        shreg_reg <= shift_word;
        if (bitcnt_reg == BIT_LAST) begin
          bitcnt_reg    <= '0;
          push_reg      <= 1'b1;
          push_data_reg <= shift_word;
        end else begin
          bitcnt_reg <= bitcnt_reg + BW'(1);
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_reg),
    .push_data (push_data_reg),
    .pop       (word_valid && word_ready),
    .head_data (word_data),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (fifo_dropped) begin
      overflow_reg <= 1'b1;
    end
  end

  assign word_valid  = !fifo_empty;
  assign overflow    = overflow_reg;
  assign frame_count = frame_count_reg;
  assign dkstrt      = dkstrt_reg;
  assign dkbsnc      = dkbsnc_reg;
  assign dkend       = dkend_reg;

endmodule

// File: tb/tb_pcm_dnlink_sim.sv
// Bench for pcm_dnlink_sim with a compact frame geometry; a tick-indexed
// frame model predicts strobes, frame count, FIFO contents and overflow.
module tb_pcm_dnlink_sim;

  localparam int BD    = 8;
  localparam int PL    = 2;
  localparam int WB    = 16;
  localparam int WPF   = 2;
  localparam int FS    = 40;
  localparam int DEPTH = 4;
  localparam int N     = WB * WPF;
  localparam int FT    = BD * FS;
  localparam int RAND_DATA = 0;
  localparam int ALT_DATA  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          agc_clk_in = 1'b0;
  logic          dkdata_in = 1'b0;
  logic          word_ready = 1'b0;
  logic          dkstrt, dkbsnc, dkend;
  logic [WB-1:0] word_data;
  logic          word_valid;
  logic          overflow;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;

  int            k;
  int            frames;
  logic [WB-1:0] mword;
  logic [WB-1:0] exp_q[$];
  logic          ovf_exp;
  logic [WB-1:0] last_word;
  logic [WB-1:0] alt_pattern;

  always #5 clk = ~clk;

  pcm_dnlink_sim #(
    .BIT_DIV         (BD),
    .PULSE_LEN       (PL),
    .WORD_BITS       (WB),
    .WORDS_PER_FRAME (WPF),
    .FRAME_SLOTS     (FS),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .agc_clk_in  (agc_clk_in),
    .dkdata_in   (dkdata_in),
    .dkstrt      (dkstrt),
    .dkbsnc      (dkbsnc),
    .dkend       (dkend),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: k counts CLK edges since the current frame began; FT-1 also means parked.
  task automatic model_reset();
    k      = FT - 1;
    frames = 0;
    exp_q.delete();
    ovf_exp = 1'b0;
    mword   = '0;
  endtask

  task automatic model_advance();
    if (k == FT - 1) begin
      if (enable) begin
        k      = 0;
        frames = (frames + 1) % 65536;
      end
    end else begin
      k++;
    end
  endtask

  task automatic model_capture(input logic d);
    int s;
    int p;
    s = k / BD;
    p = k % BD;
    if (s >= 1 && s <= N && p == PL) begin
      mword = {mword[WB-2:0], d};
      if ((s - 1) % WB == WB - 1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(mword);
        else ovf_exp = 1'b1;
      end
    end
  endtask

  function automatic logic [2:0] exp_strobes();
    int s;
    int p;
    s = k / BD;
    p = k % BD;
    if (p >= PL) return 3'b000;
    if (s == 0) return 3'b100;
    if (s <= N) return 3'b010;
    if (s == N + 1) return 3'b001;
    return 3'b000;
  endfunction

  task automatic check_state();
    chk("strobes", {61'd0, dkstrt, dkbsnc, dkend}, {61'd0, exp_strobes()});
    chk("frame_count", {48'd0, frame_count}, 64'(frames));
    chk("overflow", {63'd0, overflow}, {63'd0, ovf_exp});
    chk("word_valid", {63'd0, word_valid}, {63'd0, exp_q.size() != 0});
  endtask

  // One CLK period: 4 fabric cycles high, 4 low; called and returns on a negedge.
  task automatic tick(input int mode);
    logic d;
    model_advance();
    if (mode == ALT_DATA) d = 1'((k / BD) % 2);
    else d = 1'($urandom_range(0, 1));
    model_capture(d);
    dkdata_in  = d;
    agc_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    agc_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    check_state();
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) tick(mode);
  endtask

  // Consumer side: every accepted word must be the oldest one the model expects.
  always begin
    @(negedge clk);
    #1;
    if (!rst && word_valid && word_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL word_unexpected: observed %0h expected no word", word_data);
      end
      if (exp_q.size() != 0) begin
        chk("word_data", {48'd0, word_data}, {48'd0, exp_q.pop_front()});
        last_word = word_data;
      end
    end
  end

  initial begin
    model_reset();
    alt_pattern = 16'hAAAA;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {61'd0, dkstrt, dkbsnc, dkend}, 64'd0);
    chk("rst_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_frame_count", {48'd0, frame_count}, 64'd0);

    rst = 1'b0;
    enable = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);

    // First tick: dkstrt must appear exactly 4 cycles after the CLK rise.
    model_advance();
    model_capture(1'b0);
    dkdata_in  = 1'b0;
    agc_clk_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("dkstrt_before", {63'd0, dkstrt}, 64'd0);
    @(negedge clk);
    chk("dkstrt_first", {63'd0, dkstrt}, 64'd1);
    agc_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    check_state();

    run(FT - 1, RAND_DATA);
    chk("frame1_count", {48'd0, frame_count}, 64'd1);

    run(FT, ALT_DATA);
    chk("alt_word", {48'd0, last_word}, {48'd0, alt_pattern});
    chk("frame2_count", {48'd0, frame_count}, 64'd2);

    // Backpressure for three frames: six words into a four-deep buffer.
    word_ready = 1'b0;
    run(3 * FT, RAND_DATA);
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    chk("held_valid", {63'd0, word_valid}, 64'd1);
    chk("held_head", {48'd0, word_data}, {48'd0, exp_q[0]});
    chk("held_count", 64'(exp_q.size()), 64'(DEPTH));

    word_ready = 1'b1;
    run(FT, RAND_DATA);

    // Drop enable mid-frame: frame must finish, then park until re-enabled.
    run(10 * BD + 1, RAND_DATA);
    enable = 1'b0;
    run(FT - 1 - 10 * BD, RAND_DATA);
    run(40, RAND_DATA);
    chk("parked_count", {48'd0, frame_count}, 64'(frames));
    enable = 1'b1;
    run(FT, RAND_DATA);

    // Reset while a BSNC strobe is high partway through the second word.
    run(20 * BD + PL, RAND_DATA);
    chk("bsnc_before_rst", {63'd0, dkbsnc}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", {61'd0, dkstrt, dkbsnc, dkend}, 64'd0);
    chk("midrst_valid", {63'd0, word_valid}, 64'd0);
    chk("midrst_overflow", {63'd0, overflow}, 64'd0);
    chk("midrst_frame_count", {48'd0, frame_count}, 64'd0);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    run(FT, RAND_DATA);
    chk("restart_count", {48'd0, frame_count}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
